// File: rtl/jedro_1_instr_mem_pkg.sv
// rtl/jedro_1_instr_mem_pkg.sv - shared constants and loader state type for the instruction memory
package jedro_1_defines;

   localparam int          DATA_WIDTH = 32;
   localparam logic [31:0] BOOT_ADDR  = 32'h8000_0000;
   // addi x0, x0, 1: harmless filler returned for any address outside the array
   localparam logic [31:0] NOP_INSTR  = 32'h0010_0013;

   typedef enum logic [1:0] {
      LDR_LEN,
      LDR_DATA,
      LDR_DONE,
      LDR_ERR
   } loader_state_e;

endpackage

// File: rtl/jedro_1_instr_mem_if.sv
// rtl/jedro_1_instr_mem_if.sv - single-way instruction RAM bus between IFU and instruction memory
interface if_ram_1way;
   import jedro_1_defines::*;

   logic [DATA_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport MASTER (output ram_addr, input ram_rdata);
   modport SLAVE  (input ram_addr, output ram_rdata);

endinterface

// File: rtl/jedro_1_instr_mem_loader.sv
// rtl/jedro_1_instr_mem_loader.sv - boot loader: length header then little-endian words into the array
module jedro_1_mem_loader
   import jedro_1_defines::*;
#(
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter bit LOADER_EN       = 1'b1,
   localparam int AW             = $clog2(MEM_DEPTH_WORDS),
   localparam int IDXW           = AW + 1
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic [7:0]    load_byte_i,
   input  logic          load_valid_i,
   output logic          load_ready_o,
   output logic          load_done_o,
   output logic          load_err_o,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_idx_o,
   output logic [31:0]   wr_data_o
);

   loader_state_e    r_state;
   loader_state_e    w_state_nxt;
   logic [1:0]       r_byte_cnt;
   logic [23:0]      r_part;
   logic [31:0]      r_word_count;
   logic [IDXW-1:0]  r_wr_idx;

   logic             w_ready;
   logic             w_xfer;
   logic             w_last;
   logic [31:0]      w_word;
   logic [31:0]      w_idx_inc;

   // ready depends on state alone so there is no path from load_valid_i
   assign w_ready   = (r_state == LDR_LEN) || (r_state == LDR_DATA);
   assign w_xfer    = load_valid_i & w_ready;
   assign w_last    = w_xfer & (r_byte_cnt == 2'd3);
   assign w_word    = {load_byte_i, r_part};
   assign w_idx_inc = 32'(r_wr_idx) + 32'd1;

   assign load_ready_o = w_ready;
   assign load_done_o  = (r_state == LDR_DONE);
   assign load_err_o   = (r_state == LDR_ERR);
   assign wr_idx_o     = r_wr_idx[AW-1:0];
   assign wr_data_o    = w_word;

   // state register; loading is skipped entirely when the loader is disabled
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= LOADER_EN ? LDR_LEN : LDR_DONE;
      else         r_state <= w_state_nxt;
   end

   // next state and array write strobe, decided on the 4th byte of each word
   always_comb begin
      w_state_nxt = r_state;
      wr_en_o     = 1'b0;
      case (r_state)
         LDR_LEN: begin
            if (w_last) begin
               if (w_word == 32'd0)                          w_state_nxt = LDR_DONE;
               else if (w_word > 32'(MEM_DEPTH_WORDS))       w_state_nxt = LDR_ERR;
               else                                          w_state_nxt = LDR_DATA;
            end
         end
         LDR_DATA: begin
            if (w_last) begin
               wr_en_o = 1'b1;
               if (w_idx_inc == r_word_count) w_state_nxt = LDR_DONE;
            end
         end
         default: ;
      endcase
   end

   // byte assembler and counters; idle cycles leave everything untouched
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_byte_cnt   <= 2'd0;
         r_part       <= 24'd0;
         r_word_count <= 32'd0;
         r_wr_idx     <= '0;
      end else if (w_xfer) begin
         r_byte_cnt <= r_byte_cnt + 2'd1;
         case (r_byte_cnt)
            2'd0:    r_part[7:0]   <= load_byte_i;
            2'd1:    r_part[15:8]  <= load_byte_i;
            2'd2:    r_part[23:16] <= load_byte_i;
            default: ;
         endcase
         if (w_last && (r_state == LDR_LEN)) r_word_count <= w_word;
         if (wr_en_o)                        r_wr_idx     <= r_wr_idx + IDXW'(1);
      end
   end

endmodule

// File: rtl/jedro_1_instr_mem.sv
// rtl/jedro_1_instr_mem.sv - instruction memory with registered read port and boot loader
module jedro_1_instr_mem
   import jedro_1_defines::*;
#(
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter bit LOADER_EN       = 1'b1
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   if_ram_1way.SLAVE  if_instr_mem,
   input  logic [7:0] load_byte_i,
   input  logic       load_valid_i,
   output logic       load_ready_o,
   output logic       load_done_o,
   output logic       load_err_o,
   output logic       core_rstn_o
);

   localparam int AW = $clog2(MEM_DEPTH_WORDS);

   logic [31:0]   r_mem [MEM_DEPTH_WORDS];
   logic [31:0]   r_rdata;

   logic          w_wr_en;
   logic [AW-1:0] w_wr_idx;
   logic [31:0]   w_wr_data;
   logic [31:0]   w_off;
   logic          w_oob;
   logic [AW-1:0] w_rd_idx;

   jedro_1_mem_loader #(
      .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS),
      .LOADER_EN       (LOADER_EN)
   ) u_loader (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .load_byte_i  (load_byte_i),
      .load_valid_i (load_valid_i),
      .load_ready_o (load_ready_o),
      .load_done_o  (load_done_o),
      .load_err_o   (load_err_o),
      .wr_en_o      (w_wr_en),
      .wr_idx_o     (w_wr_idx),
      .wr_data_o    (w_wr_data)
   );

   // addresses below the boot address wrap to huge offsets, so test that case explicitly
   assign w_off    = if_instr_mem.ram_addr - BOOT_ADDR;
   assign w_oob    = (if_instr_mem.ram_addr < BOOT_ADDR) || ((w_off >> 2) >= 32'(MEM_DEPTH_WORDS));
   assign w_rd_idx = w_off[AW+1:2];

   // array write; contents deliberately survive reset
   always_ff @(posedge clk_i) begin
      if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
   end

   // registered read every cycle; a same-edge write is seen on the following read
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_rdata <= NOP_INSTR;
      else         r_rdata <= w_oob ? NOP_INSTR : r_mem[w_rd_idx];
   end

   assign if_instr_mem.ram_rdata = r_rdata;
   assign core_rstn_o            = load_done_o & rstn_i;

endmodule

// File: tb/tb_jedro_1_instr_mem.sv
// tb/tb_jedro_1_instr_mem.sv - directed bench for the instruction memory and boot loader
module tb_jedro_1_instr_mem;
   import jedro_1_defines::*;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rstn0, rstn1;
   logic [7:0] lb;
   logic       lv;
   logic       ready0, done0, err0, crst0;
   logic       ready1, done1, err1, crst1;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   if_ram_1way ram0 ();
   if_ram_1way ram1 ();

   jedro_1_instr_mem #(.MEM_DEPTH_WORDS(DEPTH), .LOADER_EN(1'b0)) u_dut0 (
      .clk_i        (clk),
      .rstn_i       (rstn0),
      .if_instr_mem (ram0),
      .load_byte_i  (lb),
      .load_valid_i (lv),
      .load_ready_o (ready0),
      .load_done_o  (done0),
      .load_err_o   (err0),
      .core_rstn_o  (crst0)
   );

   jedro_1_instr_mem #(.MEM_DEPTH_WORDS(DEPTH), .LOADER_EN(1'b1)) u_dut1 (
      .clk_i        (clk),
      .rstn_i       (rstn1),
      .if_instr_mem (ram1),
      .load_byte_i  (lb),
      .load_valid_i (lv),
      .load_ready_o (ready1),
      .load_done_o  (done1),
      .load_err_o   (err1),
      .core_rstn_o  (crst1)
   );

   function automatic logic [31:0] pat_a(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0101_0003;
   endfunction

   function automatic logic [31:0] pat_b(input int i);
      return 32'hCAFE_0000 ^ (32'(i) * 32'h0011_0111);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      lb = b;
      lv = 1'b1;
      vectors++;
      if (ready1 !== 1'b1) begin
         miscompares++;
         $display("FAIL send_ready got %b want 1", ready1);
      end
      @(negedge clk);
      lv = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
   endtask

   task automatic reset1();
      @(negedge clk);
      rstn1 = 1'b0;
      repeat (2) @(negedge clk);
      rstn1 = 1'b1;
   endtask

   task automatic read1(input logic [31:0] addr, output logic [31:0] data);
      ram1.ram_addr = addr;
      @(negedge clk);
      data = ram1.ram_rdata;
   endtask

   task automatic test_reset();
      logic [4:0] got, exp;
      #12;
      got = {ready1, done1, err1, crst1, 1'b0};
      exp = 5'b1_0_0_0_0;
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL reset_flags1 got %b want %b", got, exp); end
      vectors++;
      if (ram1.ram_rdata !== NOP_INSTR) begin miscompares++; $display("FAIL reset_rdata1 got %h want %h", ram1.ram_rdata, NOP_INSTR); end
      got = {ready0, done0, err0, crst0, 1'b0};
      exp = 5'b0_1_0_0_0;
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL reset_flags0 got %b want %b", got, exp); end
      @(negedge clk);
      rstn0 = 1'b1;
      rstn1 = 1'b1;
      #1;
      vectors++;
      if ({done0, crst0, ready0} !== 3'b110) begin miscompares++; $display("FAIL noloader_release got %b want 110", {done0, crst0, ready0}); end
      ram0.ram_addr = BOOT_ADDR + 32'(4 * DEPTH);
      lv = 1'b1;
      @(negedge clk);
      lv = 1'b0;
      vectors++;
      if (ram0.ram_rdata !== NOP_INSTR) begin miscompares++; $display("FAIL noloader_oob got %h want %h", ram0.ram_rdata, NOP_INSTR); end
      vectors++;
      if ({done0, ready0, err0} !== 3'b100) begin miscompares++; $display("FAIL noloader_ignore got %b want 100", {done0, ready0, err0}); end
   endtask

   task automatic test_two_words();
      logic [31:0] d;
      reset1();
      send_word(32'h0000_0002, 0);
      send_word(32'h0010_0513, 0);
      send_byte(8'h93);
      send_byte(8'h05);
      send_byte(8'h20);
      vectors++;
      if (done1 !== 1'b0) begin miscompares++; $display("FAIL two_done_early got %b want 0", done1); end
      send_byte(8'h00);
      vectors++;
      if ({done1, crst1, ready1, err1} !== 4'b1100) begin miscompares++; $display("FAIL two_done got %b want 1100", {done1, crst1, ready1, err1}); end
      read1(BOOT_ADDR + 32'd4, d);
      vectors++;
      if (d !== 32'h0020_0593) begin miscompares++; $display("FAIL two_word1 got %h want 00200593", d); end
      read1(BOOT_ADDR, d);
      vectors++;
      if (d !== 32'h0010_0513) begin miscompares++; $display("FAIL two_word0 got %h want 00100513", d); end
   endtask

   task automatic test_len_err();
      reset1();
      send_word(32'hFFFF_FFFF, 0);
      vectors++;
      if ({err1, done1, crst1, ready1} !== 4'b1000) begin miscompares++; $display("FAIL err_flags got %b want 1000", {err1, done1, crst1, ready1}); end
      lv = 1'b1;
      lb = 8'h55;
      repeat (3) @(negedge clk);
      lv = 1'b0;
      vectors++;
      if ({err1, ready1} !== 2'b10) begin miscompares++; $display("FAIL err_sticky got %b want 10", {err1, ready1}); end
      reset1();
      send_word(32'd17, 0);
      vectors++;
      if ({err1, done1} !== 2'b10) begin miscompares++; $display("FAIL err_depth_plus1 got %b want 10", {err1, done1}); end
      reset1();
      send_word(32'd0, 0);
      vectors++;
      if ({err1, done1, crst1} !== 3'b011) begin miscompares++; $display("FAIL len_zero got %b want 011", {err1, done1, crst1}); end
   endtask

   task automatic test_full_and_gaps();
      logic [31:0] d;
      reset1();
      send_word(32'd16, 0);
      for (int i = 0; i < DEPTH; i++) send_word(pat_a(i), 0);
      vectors++;
      if (done1 !== 1'b1) begin miscompares++; $display("FAIL full_done got %b want 1", done1); end
      for (int i = 0; i < DEPTH; i++) begin
         read1(BOOT_ADDR + 32'(4 * i), d);
         vectors++;
         if (d !== pat_a(i)) begin miscompares++; $display("FAIL full_word%0d got %h want %h", i, d, pat_a(i)); end
      end
      read1(BOOT_ADDR + 32'(4 * 15 + 3), d);
      vectors++;
      if (d !== pat_a(15)) begin miscompares++; $display("FAIL low_bits got %h want %h", d, pat_a(15)); end
      read1(BOOT_ADDR + 32'(4 * DEPTH), d);
      vectors++;
      if (d !== NOP_INSTR) begin miscompares++; $display("FAIL oob_high got %h want %h", d, NOP_INSTR); end
      read1(BOOT_ADDR - 32'd4, d);
      vectors++;
      if (d !== NOP_INSTR) begin miscompares++; $display("FAIL oob_low got %h want %h", d, NOP_INSTR); end
      reset1();
      send_word(32'd16, 5);
      for (int i = 0; i < DEPTH; i++) send_word(pat_b(i), 5);
      vectors++;
      if (done1 !== 1'b1) begin miscompares++; $display("FAIL gap_done got %b want 1", done1); end
      for (int i = 0; i < DEPTH; i++) begin
         read1(BOOT_ADDR + 32'(4 * i), d);
         vectors++;
         if (d !== pat_b(i)) begin miscompares++; $display("FAIL gap_word%0d got %h want %h", i, d, pat_b(i)); end
      end
   endtask

   task automatic test_reset_midload();
      logic [31:0] d;
      logic [31:0] nw [3];
      nw[0] = 32'hAAAA_0001;
      nw[1] = 32'hBBBB_0002;
      nw[2] = 32'hCCCC_0003;
      reset1();
      send_word(32'd3, 0);
      send_word(32'h1111_1111, 0);
      send_byte(8'h22);
      send_byte(8'h22);
      #2;
      rstn1 = 1'b0;
      #1;
      vectors++;
      if ({crst1, ready1, done1} !== 3'b010) begin miscompares++; $display("FAIL async_reset got %b want 010", {crst1, ready1, done1}); end
      @(negedge clk);
      rstn1 = 1'b1;
      send_word(32'd3, 0);
      send_byte(nw[0][7:0]);
      send_byte(nw[0][15:8]);
      send_byte(nw[0][23:16]);
      ram1.ram_addr = BOOT_ADDR;
      send_byte(nw[0][31:24]);
      vectors++;
      if (ram1.ram_rdata !== 32'h1111_1111) begin miscompares++; $display("FAIL rd_wr_collide got %h want 11111111", ram1.ram_rdata); end
      @(negedge clk);
      vectors++;
      if (ram1.ram_rdata !== nw[0]) begin miscompares++; $display("FAIL after_write got %h want %h", ram1.ram_rdata, nw[0]); end
      send_word(nw[1], 0);
      send_word(nw[2], 0);
      vectors++;
      if (done1 !== 1'b1) begin miscompares++; $display("FAIL reload_done got %b want 1", done1); end
      for (int i = 0; i < 3; i++) begin
         read1(BOOT_ADDR + 32'(4 * i), d);
         vectors++;
         if (d !== nw[i]) begin miscompares++; $display("FAIL reload_word%0d got %h want %h", i, d, nw[i]); end
      end
   endtask

   initial begin
      rstn0         = 1'b0;
      rstn1         = 1'b0;
      lb            = 8'h00;
      lv            = 1'b0;
      ram0.ram_addr = BOOT_ADDR;
      ram1.ram_addr = BOOT_ADDR;
      test_reset();
      test_two_words();
      test_len_err();
      test_full_and_gaps();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
